// File: rtl/sat_bin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_bin_pkg
// Description : Shared variable-word encodings and BCP controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_bin_pkg;

    localparam int VAR_W = 3;

    // Low two bits of a variable word; bit 2 is the drv flag
    localparam logic [1:0] FREE  = 2'b00;
    localparam logic [1:0] FALSE = 2'b01;
    localparam logic [1:0] TRUE  = 2'b10;
    localparam logic [1:0] CONFL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROP  = 3'd1,
        ST_DONE  = 3'd2,
        ST_CONFL = 3'd3,
        ST_BTRK  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/var_merge.sv
`default_nettype none
// ============================================================================
// Module      : var_merge
// Description : Merges all clause requests for one variable into its next word.
// Revision    : 1.0 - initial release
// ============================================================================
module var_merge
    import sat_bin_pkg::*;
#(
    parameter int NUM_CLAUSES = 4
) (
    input  logic [NUM_CLAUSES*VAR_W-1:0] clause_words_i,
    input  logic [VAR_W-1:0]             cur_i,
    output logic [VAR_W-1:0]             next_o,
    output logic                         new_imp_o,
    output logic                         conflict_o
);

    logic w_true_req;
    logic w_false_req;
    logic w_bad_word;
    logic w_opposed;

    always_comb begin
        w_true_req  = 1'b0;
        w_false_req = 1'b0;
        w_bad_word  = 1'b0;
        for (int k = 0; k < NUM_CLAUSES; k++) begin
            if (clause_words_i[k*VAR_W+2]) begin
                if (clause_words_i[k*VAR_W +: 2] == TRUE)  w_true_req  = 1'b1;
                if (clause_words_i[k*VAR_W +: 2] == FALSE) w_false_req = 1'b1;
                if (clause_words_i[k*VAR_W +: 2] == CONFL) w_bad_word  = 1'b1;
            end
        end
    end

    // A variable already in conflict is opposed by any request at all
    assign w_opposed  = (w_true_req  && (cur_i[1:0] == FALSE)) ||
                        (w_false_req && (cur_i[1:0] == TRUE))  ||
                        ((w_true_req || w_false_req) && (cur_i[1:0] == CONFL));

    assign conflict_o = w_bad_word || (w_true_req && w_false_req) || w_opposed;
    assign new_imp_o  = !w_bad_word && (cur_i[1:0] == FREE) && (w_true_req ^ w_false_req);
    assign next_o     = new_imp_o ? {1'b1, (w_true_req ? TRUE : FALSE)} : cur_i;

endmodule
`default_nettype wire

// File: rtl/bcp_base.sv
`default_nettype none
// ============================================================================
// Module      : bcp_base
// Description : Boolean constraint propagation controller for one variable bin.
// Revision    : 1.0 - initial release
// ============================================================================
module bcp_base
    import sat_bin_pkg::*;
#(
    parameter int NUM_VARS_A_BIN = 8,
    parameter int NUM_CLAUSES    = 4,
    parameter int MAX_ITER       = 15
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    load_i,
    input  logic [NUM_VARS_A_BIN*VAR_W-1:0]         var_value_i,
    input  logic                                    start_i,
    input  logic                                    backtrack_i,
    output logic [NUM_VARS_A_BIN*VAR_W-1:0]         var_value_frombase_o,
    input  logic [NUM_CLAUSES*NUM_VARS_A_BIN*VAR_W-1:0] var_value_tobase_i,
    output logic                                    apply_backtrack_o,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    conflict_o,
    output logic [4:0]                              imp_cnt_o
);

    localparam int c_TAB_W  = NUM_VARS_A_BIN * VAR_W;
    localparam int c_ITER_W = (MAX_ITER > 1) ? $clog2(MAX_ITER + 1) : 1;
    localparam int c_CNT_W  = $clog2(NUM_VARS_A_BIN + 1);
    localparam int c_SUM_W  = ((c_CNT_W > 5) ? c_CNT_W : 5) + 1;

    state_t                r_state;
    logic [c_TAB_W-1:0]    r_table;
    logic [c_ITER_W-1:0]   r_iter;
    logic [4:0]            r_imp_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_conflict;
    logic                  r_apply_bt;

    logic [c_TAB_W-1:0]        w_next_table;
    logic [c_TAB_W-1:0]        w_bt_table;
    logic [NUM_VARS_A_BIN-1:0] w_new_imp;
    logic [NUM_VARS_A_BIN-1:0] w_conflict;
    logic [c_CNT_W-1:0]        w_imp_add;
    logic [c_SUM_W-1:0]        w_imp_sum;
    logic [4:0]                w_imp_sat;

    generate
        for (genvar v = 0; v < NUM_VARS_A_BIN; v++) begin : g_var
            logic [NUM_CLAUSES*VAR_W-1:0] w_words;

            // Gather this variable's word from every clause slice
            for (genvar k = 0; k < NUM_CLAUSES; k++) begin : g_cl
                assign w_words[k*VAR_W +: VAR_W] =
                    var_value_tobase_i[(k*NUM_VARS_A_BIN + v)*VAR_W +: VAR_W];
            end

            var_merge #(
                .NUM_CLAUSES (NUM_CLAUSES)
            ) u_var_merge (
                .clause_words_i (w_words),
                .cur_i          (r_table[v*VAR_W +: VAR_W]),
                .next_o         (w_next_table[v*VAR_W +: VAR_W]),
                .new_imp_o      (w_new_imp[v]),
                .conflict_o     (w_conflict[v])
            );

            assign w_bt_table[v*VAR_W +: VAR_W] =
                r_table[v*VAR_W+2] ? '0 : r_table[v*VAR_W +: VAR_W];
        end
    endgenerate

    always_comb begin
        w_imp_add = '0;
        for (int v = 0; v < NUM_VARS_A_BIN; v++) begin
            w_imp_add = w_imp_add + c_CNT_W'(w_new_imp[v]);
        end
    end

    assign w_imp_sum = c_SUM_W'(r_imp_cnt) + c_SUM_W'(w_imp_add);
    assign w_imp_sat = (w_imp_sum > c_SUM_W'(31)) ? 5'd31 : w_imp_sum[4:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_table    <= '0;
            r_iter     <= '0;
            r_imp_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
            r_apply_bt <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
            r_apply_bt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (backtrack_i) begin
                        r_state    <= ST_BTRK;
                        r_busy     <= 1'b1;
                        r_apply_bt <= 1'b1;
                    end else if (load_i) begin
                        r_table   <= var_value_i;
                        r_imp_cnt <= '0;
                    end else if (start_i) begin
                        r_state <= ST_PROP;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PROP: begin
                    r_iter <= r_iter + c_ITER_W'(1);
                    if (|w_conflict) begin
                        r_state    <= ST_CONFL;
                        r_conflict <= 1'b1;
                    end else begin
                        r_table   <= w_next_table;
                        r_imp_cnt <= w_imp_sat;
                        if (!(|w_new_imp)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (r_iter == c_ITER_W'(MAX_ITER - 1)) begin
                            r_state    <= ST_CONFL;
                            r_conflict <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_CONFL: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                ST_BTRK: begin
                    r_table   <= w_bt_table;
                    r_imp_cnt <= '0;
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign var_value_frombase_o = r_table;
    assign apply_backtrack_o    = r_apply_bt;
    assign busy_o               = r_busy;
    assign done_o               = r_done;
    assign conflict_o           = r_conflict;
    assign imp_cnt_o            = r_imp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bcp_base.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcp_base
// Description : Self-checking bench for bcp_base with emulated clause units.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcp_base;
    import sat_bin_pkg::*;

    localparam int NV = 16;
    localparam int NC = 4;
    localparam int MI = 15;
    localparam int NR = 16;
    localparam int TW = NV * 3;
    localparam int CW = NC * NV * 3;

    // Clause emulation rule: when var src holds sv (or always), clause cl drives dst with dw
    typedef struct packed {
        logic       en;
        logic       always_on;
        logic [1:0] cl;
        logic [3:0] src;
        logic [1:0] sv;
        logic [3:0] dst;
        logic [2:0] dw;
    } rule_t;

    logic          clk = 1'b0;
    logic          rst, load_i, start_i, backtrack_i;
    logic [TW-1:0] var_value_i, frombase;
    logic [CW-1:0] tobase;
    logic          apply_bt, busy, done, confl;
    logic [4:0]    imp_cnt;

    rule_t [NR-1:0] rules;
    int             checks = 0;
    int             errors = 0;
    logic [TW-1:0]  m_tab;
    int             m_imp;

    bcp_base #(
        .NUM_VARS_A_BIN (NV),
        .NUM_CLAUSES    (NC),
        .MAX_ITER       (MI)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_i               (load_i),
        .var_value_i          (var_value_i),
        .start_i              (start_i),
        .backtrack_i          (backtrack_i),
        .var_value_frombase_o (frombase),
        .var_value_tobase_i   (tobase),
        .apply_backtrack_o    (apply_bt),
        .busy_o               (busy),
        .done_o               (done),
        .conflict_o           (confl),
        .imp_cnt_o            (imp_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] clause_out(input logic [TW-1:0] tab, input rule_t [NR-1:0] rs);
        logic [CW-1:0] o;
        o = '0;
        for (int r = 0; r < NR; r++) begin
            if (rs[r].en && (rs[r].always_on || tab[rs[r].src*3 +: 2] == rs[r].sv))
                o[(rs[r].cl*NV + rs[r].dst)*3 +: 3] = o[(rs[r].cl*NV + rs[r].dst)*3 +: 3] | rs[r].dw;
        end
        return o;
    endfunction

    assign tobase = clause_out(frombase, rules);

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: iterate propagation rounds on the bench's own table copy
    task automatic run_model(output int outcome, output int iters);
        logic [CW-1:0] cw;
        logic [TW-1:0] nxt;
        logic [2:0]    w;
        logic [1:0]    cur;
        bit            t, f, c, conf;
        int            nimp;
        outcome = 1;
        iters   = MI;
        for (int it = 1; it <= MI; it++) begin
            cw = clause_out(m_tab, rules);
            nxt = m_tab; conf = 0; nimp = 0;
            for (int v = 0; v < NV; v++) begin
                t = 0; f = 0; c = 0;
                for (int k = 0; k < NC; k++) begin
                    w = cw[(k*NV + v)*3 +: 3];
                    if (w == 3'b110) t = 1;
                    else if (w == 3'b101) f = 1;
                    else if (w == 3'b111) c = 1;
                end
                cur = m_tab[v*3 +: 2];
                if (c || (t && f) ||
                    (cur != FREE && (t || f) && !((t && cur == TRUE) || (f && cur == FALSE))))
                    conf = 1;
                else if (cur == FREE && (t || f)) begin
                    nxt[v*3 +: 3] = {1'b1, (t ? TRUE : FALSE)};
                    nimp++;
                end
            end
            if (conf) begin
                outcome = 1; iters = it;
                return;
            end
            m_tab = nxt;
            m_imp = (m_imp + nimp > 31) ? 31 : m_imp + nimp;
            if (nimp == 0) begin
                outcome = 0; iters = it;
                return;
            end
        end
    endtask

    task automatic do_load(input logic [TW-1:0] v);
        load_i = 1'b1; var_value_i = v;
        @(posedge clk); #1;
        load_i = 1'b0;
        m_tab = v; m_imp = 0;
    endtask

    task automatic run_prop(input string tag, input bit inject_load);
        int exp_out, exp_it, n;
        run_model(exp_out, exp_it);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 1;
        while (!done && !confl && n < 40) begin
            if (inject_load && n == 3) begin
                load_i = 1'b1; var_value_i = '0; start_i = 1'b1;
            end
            @(posedge clk); #1;
            load_i = 1'b0; start_i = 1'b0;
            n++;
        end
        chk_eq({tag, "_latency"}, n, exp_it + 1);
        chk_eq({tag, "_done"}, done, exp_out == 0);
        chk_eq({tag, "_conflict"}, confl, exp_out == 1);
        @(posedge clk); #1;
        chk_eq({tag, "_idle_after"}, {busy, done, confl}, 3'b000);
        chk_eq({tag, "_table"}, frombase, m_tab);
        chk_eq({tag, "_imp_cnt"}, imp_cnt, m_imp);
    endtask

    task automatic do_backtrack(input string tag, input bit also_ls);
        backtrack_i = 1'b1;
        if (also_ls) begin
            load_i = 1'b1; start_i = 1'b1; var_value_i = '1;
        end
        @(posedge clk); #1;
        backtrack_i = 1'b0; load_i = 1'b0; start_i = 1'b0;
        chk_eq({tag, "_apply_hi"}, {apply_bt, busy}, 2'b11);
        @(posedge clk); #1;
        chk_eq({tag, "_apply_lo"}, {apply_bt, busy}, 2'b00);
        for (int v = 0; v < NV; v++)
            if (m_tab[v*3+2]) m_tab[v*3 +: 3] = 3'b000;
        m_imp = 0;
        chk_eq({tag, "_table"}, frombase, m_tab);
        chk_eq({tag, "_imp_cnt"}, imp_cnt, 0);
    endtask

    task automatic set_chain(input int len);
        rules = '0;
        for (int r = 0; r < len; r++) begin
            rules[r].en  = 1'b1;
            rules[r].cl  = 2'(r % NC);
            rules[r].src = 4'(r);
            rules[r].sv  = TRUE;
            rules[r].dst = 4'(r + 1);
            rules[r].dw  = 3'b110;
        end
    endtask

    initial begin
        logic [TW-1:0] tv;
        bit            seen;
        rst = 1'b1; load_i = 1'b0; start_i = 1'b0; backtrack_i = 1'b0;
        var_value_i = '0; rules = '0; m_tab = '0; m_imp = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_flags", {busy, done, confl, apply_bt}, 4'b0000);
        chk_eq("reset_table", frombase, 0);
        chk_eq("reset_imp", imp_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Idle clauses: nothing to imply
        tv = '0; tv[1*3 +: 3] = 3'b010; tv[3*3 +: 3] = 3'b100;
        do_load(tv);
        run_prop("idle", 1'b0);

        // Single implication then quiescence
        rules = '0;
        rules[0] = '{en: 1'b1, always_on: 1'b1, cl: 2'd0, src: 4'd0, sv: FREE, dst: 4'd3, dw: 3'b101};
        tv = '0; tv[1*3 +: 3] = 3'b010;
        do_load(tv);
        run_prop("single", 1'b0);

        // Two clauses disagree on var5
        rules = '0;
        rules[0] = '{en: 1'b1, always_on: 1'b1, cl: 2'd0, src: 4'd0, sv: FREE, dst: 4'd5, dw: 3'b110};
        rules[1] = '{en: 1'b1, always_on: 1'b1, cl: 2'd1, src: 4'd0, sv: FREE, dst: 4'd5, dw: 3'b101};
        do_load(tv);
        run_prop("clash", 1'b0);

        // Long chain hits the iteration limit; a load during PROP must be ignored
        set_chain(15);
        tv = '0; tv[2:0] = 3'b010;
        do_load(tv);
        run_prop("maxiter", 1'b1);

        // Two implications, then backtrack keeps loaded words
        set_chain(2);
        rules[1].dw = 3'b101;
        tv = '0; tv[2:0] = 3'b010; tv[7*3 +: 3] = 3'b001;
        do_load(tv);
        run_prop("pre_bt", 1'b0);
        do_backtrack("bt", 1'b0);

        // load beats start
        tv = '0; tv[9*3 +: 3] = 3'b001;
        load_i = 1'b1; start_i = 1'b1; var_value_i = tv;
        @(posedge clk); #1;
        load_i = 1'b0; start_i = 1'b0;
        m_tab = tv; m_imp = 0;
        chk_eq("load_prio_busy", busy, 1'b0);
        chk_eq("load_prio_table", frombase, tv);

        // backtrack beats load and start
        do_backtrack("bt_prio", 1'b1);

        // Reset during the second PROP cycle
        set_chain(8);
        tv = '0; tv[2:0] = 3'b010;
        do_load(tv);
        seen = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        seen = seen | done | confl;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_eq("rst_mid_flags", {busy, done, confl, apply_bt}, 4'b0000);
        chk_eq("rst_mid_table", frombase, 0);
        chk_eq("rst_mid_imp", imp_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen = seen | done | confl;
        end
        chk_eq("rst_mid_no_pulse", seen, 1'b0);
        m_tab = '0; m_imp = 0;

        // Randomized rule sets and tables
        for (int trial = 0; trial < 40; trial++) begin
            rules = '0;
            for (int r = 0; r < NR; r++) begin
                rules[r].en        = ($urandom_range(0, 9) < 7);
                rules[r].always_on = ($urandom_range(0, 4) == 0);
                rules[r].cl        = 2'($urandom_range(0, NC - 1));
                rules[r].src       = 4'($urandom_range(0, NV - 1));
                rules[r].sv        = 2'($urandom_range(0, 2));
                rules[r].dst       = 4'($urandom_range(0, NV - 1));
                rules[r].dw        = ($urandom_range(0, 15) == 0) ? 3'b111 :
                                     ($urandom_range(0, 1) == 1 ? 3'b110 : 3'b101);
            end
            if ($urandom_range(0, 3) != 0) begin
                for (int v = 0; v < NV; v++)
                    tv[v*3 +: 3] = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
                do_load(tv);
            end
            run_prop("rand", 1'b0);
            if ($urandom_range(0, 4) == 0)
                do_backtrack("rand_bt", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
